// File: rtl/pic_inta_sequencer.sv
// -----------------------------------------------------------------------------
// pic_inta_sequencer
//
// Sequences the 8086-mode two-pulse INTA handshake of an 8259A-style PIC.
// It raises INT from the priority resolver request and freezes IRR sampling.
// On the first INTA it sets the ISR bit and, as a cascading master, drives
// the slave address on CAS. On the second INTA it drives the vector, either
// unconditionally or only when the CAS lines address this slave. After that
// it issues an automatic EOI. A watchdog aborts a handshake the CPU leaves
// open.
//
// Ports
//   clk, rst_n   : clock, synchronous active-low reset
//   inta_n       : CPU interrupt acknowledge (async, active low)
//   int_request  : unmasked request above the current ISR level
//   ir_index     : highest-priority pending IR number
//   init_done    : ICW sequence complete (low forces IDLE)
//   vector_base  : ICW2[7:3]
//   aeoi, sngl   : ICW4 AEOI, ICW1 SNGL
//   sp           : 1 = master, 0 = slave
//   slave_map    : ICW3 of a master (IRs with a slave attached)
//   slave_id     : ICW3[2:0] of a slave
//   cas_in       : CAS lines as seen by a slave (async)
//   int_out      : INT to the CPU
//   freeze       : freeze IRR sampling
//   isr_set      : one-cycle pulse, set ISR bit isr_index
//   isr_index    : IR index latched at the first INTA
//   eoi_pulse    : one-cycle pulse, clear ISR bit isr_index (AEOI)
//   vec_oe       : drive vec_data onto the internal bus
//   vec_data     : {vector_base, isr_index}
//   cas_out      : CAS value driven by a master
//   cas_oe       : master drives CAS
//   abort        : one-cycle pulse on watchdog timeout
// -----------------------------------------------------------------------------
module pic_inta_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inta_n,
   input  logic       int_request,
   input  logic [2:0] ir_index,
   input  logic       init_done,
   input  logic [4:0] vector_base,
   input  logic       aeoi,
   input  logic       sngl,
   input  logic       sp,
   input  logic [7:0] slave_map,
   input  logic [2:0] slave_id,
   input  logic [2:0] cas_in,
   output logic       int_out,
   output logic       freeze,
   output logic       isr_set,
   output logic [2:0] isr_index,
   output logic       eoi_pulse,
   output logic       vec_oe,
   output logic [7:0] vec_data,
   output logic [2:0] cas_out,
   output logic       cas_oe,
   output logic       abort
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_ACK1,
      ST_WAIT2,
      ST_ACK2,
      ST_DONE
   } state_t;

   // Synchronizers: bit/entry 0 is the first stage, the top entry feeds logic.
   logic [SYNC_STAGES-1:0]      ia_sync_q, ia_sync_d;
   logic [SYNC_STAGES-1:0][2:0] cas_sync_q, cas_sync_d;
   logic                        ia_prev_q, ia_prev_d;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          int_out_q, int_out_d;
   logic          freeze_q, freeze_d;
   logic          isr_set_q, isr_set_d;
   logic [2:0]    isr_index_q, isr_index_d;
   logic          eoi_pulse_q, eoi_pulse_d;
   logic          vec_oe_q, vec_oe_d;
   logic [2:0]    cas_out_q, cas_out_d;
   logic          cas_oe_q, cas_oe_d;
   logic          abort_q, abort_d;
   logic          spurious_q, spurious_d;

   logic       ia, fall, rise, edge_seen;
   logic [2:0] cas_s;
   logic       cas_match, in_cycle, watched, timeout_hit, vec_allow;
   logic [2:0] idx_new;

   assign ia        = ia_sync_q[SYNC_STAGES-1];
   assign cas_s     = cas_sync_q[SYNC_STAGES-1];
   assign fall      = ia_prev_q & ~ia;
   assign rise      = ~ia_prev_q & ia;
   assign edge_seen = fall | rise;
   assign cas_match = (cas_s == slave_id);
   assign in_cycle  = (state_q != ST_IDLE);
   assign watched   = (state_q == ST_REQ) || (state_q == ST_ACK1) ||
                      (state_q == ST_WAIT2) || (state_q == ST_ACK2);
   assign timeout_hit = watched & ~edge_seen & (count_q == CW'(TIMEOUT - 1));

   // Vector ownership at the second INTA: single mode, a master whose IR has
   // no slave behind it, or a slave addressed by the master over CAS.
   assign vec_allow = sngl | (sp & ~slave_map[isr_index_q]) | (~sp & cas_match);

   always_comb begin
      ia_sync_d  = {ia_sync_q[SYNC_STAGES-2:0], inta_n};
      cas_sync_d = {cas_sync_q[SYNC_STAGES-2:0], cas_in};
      ia_prev_d  = ia;
   end

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path leaves
      // one unassigned and no latch is inferred.
      state_d     = state_q;
      int_out_d   = int_out_q;
      freeze_d    = freeze_q;
      isr_index_d = isr_index_q;
      vec_oe_d    = vec_oe_q;
      cas_out_d   = cas_out_q;
      cas_oe_d    = cas_oe_q;
      spurious_d  = spurious_q;
      isr_set_d   = 1'b0;
      eoi_pulse_d = 1'b0;
      abort_d     = 1'b0;
      idx_new     = int_request ? ir_index : 3'd7;
      count_d     = '0;

      if (watched && !edge_seen) begin
         count_d = count_q + CW'(1);
      end

      if ((in_cycle && !init_done) || timeout_hit) begin
         // Drop the cycle; whatever ISR bit was set stays set.
         state_d     = ST_IDLE;
         int_out_d   = 1'b0;
         freeze_d    = 1'b0;
         isr_index_d = 3'd0;
         vec_oe_d    = 1'b0;
         cas_out_d   = 3'd0;
         cas_oe_d    = 1'b0;
         spurious_d  = 1'b0;
         count_d     = '0;
         abort_d     = timeout_hit & init_done;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (init_done && int_request) begin
                  state_d   = ST_REQ;
                  int_out_d = 1'b1;
               end
            end
            ST_REQ: begin
               // int_out is held here even if int_request drops.
               if (fall) begin
                  state_d     = ST_ACK1;
                  int_out_d   = 1'b0;
                  freeze_d    = 1'b1;
                  isr_index_d = idx_new;
                  spurious_d  = ~int_request;
                  // An unaddressed slave still walks the handshake but owns nothing.
                  isr_set_d   = int_request & (sngl | sp | cas_match);
                  if (!sngl && sp && slave_map[idx_new]) begin
                     cas_out_d = idx_new;
                     cas_oe_d  = 1'b1;
                  end
               end
            end
            ST_ACK1: begin
               if (rise) state_d = ST_WAIT2;
            end
            ST_WAIT2: begin
               if (fall) begin
                  state_d  = ST_ACK2;
                  vec_oe_d = vec_allow;
               end
            end
            ST_ACK2: begin
               if (rise) begin
                  state_d     = ST_DONE;
                  vec_oe_d    = 1'b0;
                  eoi_pulse_d = aeoi & ~spurious_q;
               end
            end
            ST_DONE: begin
               state_d    = ST_IDLE;
               freeze_d   = 1'b0;
               cas_oe_d   = 1'b0;
               cas_out_d  = 3'd0;
               vec_oe_d   = 1'b0;
               spurious_d = 1'b0;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ia_sync_q   <= '1;
         cas_sync_q  <= '0;
         ia_prev_q   <= 1'b1;
         state_q     <= ST_IDLE;
         count_q     <= '0;
         int_out_q   <= 1'b0;
         freeze_q    <= 1'b0;
         isr_set_q   <= 1'b0;
         isr_index_q <= 3'd0;
         eoi_pulse_q <= 1'b0;
         vec_oe_q    <= 1'b0;
         cas_out_q   <= 3'd0;
         cas_oe_q    <= 1'b0;
         abort_q     <= 1'b0;
         spurious_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // computed before this edge, independent of statement order.
         ia_sync_q   <= ia_sync_d;
         cas_sync_q  <= cas_sync_d;
         ia_prev_q   <= ia_prev_d;
         state_q     <= state_d;
         count_q     <= count_d;
         int_out_q   <= int_out_d;
         freeze_q    <= freeze_d;
         isr_set_q   <= isr_set_d;
         isr_index_q <= isr_index_d;
         eoi_pulse_q <= eoi_pulse_d;
         vec_oe_q    <= vec_oe_d;
         cas_out_q   <= cas_out_d;
         cas_oe_q    <= cas_oe_d;
         abort_q     <= abort_d;
         spurious_q  <= spurious_d;
      end
   end

   assign int_out   = int_out_q;
   assign freeze    = freeze_q;
   assign isr_set   = isr_set_q;
   assign isr_index = isr_index_q;
   assign eoi_pulse = eoi_pulse_q;
   assign vec_oe    = vec_oe_q;
   assign vec_data  = vec_oe_q ? {vector_base, isr_index_q} : 8'h00;
   assign cas_out   = cas_out_q;
   assign cas_oe    = cas_oe_q;
   assign abort     = abort_q;

endmodule
